// File: rtl/uart_ctrl_pkg.sv
// Shared states, register map and FR bit positions for the UART Wishbone controller.
// UART_WB_CTRL_RX_EN adds the receive-path states.
package uart_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG_LCRH,
    CFG_LCRM,
    CFG_LCRL,
    CFG_CR,
    READY,
    POLL_FR,
    WR_DR,
    ERROR
`ifdef UART_WB_CTRL_RX_EN
    ,
    RX_POLL,
    RX_RD
`endif
  } state_t;

  localparam logic [31:0] OFF_DR   = 32'h00;
  localparam logic [31:0] OFF_LCRH = 32'h08;
  localparam logic [31:0] OFF_LCRM = 32'h0C;
  localparam logic [31:0] OFF_LCRL = 32'h10;
  localparam logic [31:0] OFF_CR   = 32'h14;
  localparam logic [31:0] OFF_FR   = 32'h18;

  localparam int FR_TXFF = 5;
  localparam int FR_RXFE = 4;

  // UART registers are byte wide and live in the low lane of the bus word.
  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/uart_wb_master_if.sv
// Single-transaction Wishbone master: holds cyc/stb until ack, err or ack timeout,
// then returns to idle for at least one cycle.
module uart_wb_master_if #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] req_adr,
  input  logic        req_we,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        done,
  output logic        err,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic        wb_we,
  output logic [31:0] wb_dat,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic        wb_ack,
  input  logic        wb_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          timeout;

  // cnt holds the number of completed no-ack cycles, so this is the last allowed one.
  assign timeout = (cnt >= CW'(ACK_TIMEOUT - 1)) && !wb_ack;
  assign err     = wb_stb && (wb_err || timeout);
  assign done    = wb_stb && wb_ack && !wb_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cyc <= 1'b0;
      wb_stb <= 1'b0;
      wb_we  <= 1'b0;
      wb_adr <= '0;
      wb_dat <= '0;
      wb_sel <= '0;
      cnt    <= '0;
    end else if (wb_stb) begin
      if (wb_ack || wb_err || timeout) begin
        wb_cyc <= 1'b0;
        wb_stb <= 1'b0;
        wb_we  <= 1'b0;
        wb_adr <= '0;
        wb_dat <= '0;
        wb_sel <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CW'(1);
      end
    end else if (req) begin
      wb_cyc <= 1'b1;
      wb_stb <= 1'b1;
      wb_we  <= req_we;
      wb_adr <= req_adr;
      wb_dat <= req_dat;
      wb_sel <= req_sel;
      cnt    <= '0;
    end
  end

endmodule

// File: rtl/uart_wb_ctrl.sv
// Configures a UART over Wishbone, then forwards bytes to its data register.
// Define UART_WB_CTRL_RX_EN to also poll for and read received bytes.
module uart_wb_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [31:0] UART_BASE   = 32'h1600_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_lcrh,
  input  logic [7:0]  i_lcrm,
  input  logic [7:0]  i_lcrl,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_data,
  output logic        o_tx_ready,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
`ifdef UART_WB_CTRL_RX_EN
  output logic        o_rx_valid,
  output logic [7:0]  o_rx_data,
`endif
  output logic        o_init_done,
  output logic        o_err
);

  state_t      state, state_nx;
  logic [7:0]  lcrh_q, lcrm_q, lcrl_q, tx_byte;
  logic        req, req_we, bus_done, bus_err;
  logic [31:0] req_adr, req_dat;

  uart_wb_master_if #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_master (
    .clk     (i_clk),
    .rst     (i_rst),
    .req     (req),
    .req_adr (req_adr),
    .req_we  (req_we),
    .req_dat (req_dat),
    .req_sel (4'b0001),
    .done    (bus_done),
    .err     (bus_err),
    .wb_adr  (o_wb_adr),
    .wb_sel  (o_wb_sel),
    .wb_we   (o_wb_we),
    .wb_dat  (o_wb_dat),
    .wb_cyc  (o_wb_cyc),
    .wb_stb  (o_wb_stb),
    .wb_ack  (i_wb_ack),
    .wb_err  (i_wb_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lcrh_q  <= '0;
      lcrm_q  <= '0;
      lcrl_q  <= '0;
      tx_byte <= '0;
    end else begin
      if (state == IDLE && i_start) begin
        lcrh_q <= i_lcrh;
        lcrm_q <= i_lcrm;
        lcrl_q <= i_lcrl;
      end
      if (o_tx_ready) tx_byte <= i_tx_data;
    end
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    req_we   = 1'b0;
    req_adr  = UART_BASE;
    req_dat  = '0;
    case (state)
      IDLE:     if (i_start) state_nx = CFG_LCRH;
      CFG_LCRH: begin
        req = 1'b1; req_we = 1'b1;
        req_adr = UART_BASE + OFF_LCRH; req_dat = byte_word(lcrh_q);
        if (bus_done) state_nx = CFG_LCRM;
      end
      CFG_LCRM: begin
        req = 1'b1; req_we = 1'b1;
        req_adr = UART_BASE + OFF_LCRM; req_dat = byte_word(lcrm_q);
        if (bus_done) state_nx = CFG_LCRL;
      end
      CFG_LCRL: begin
        req = 1'b1; req_we = 1'b1;
        req_adr = UART_BASE + OFF_LCRL; req_dat = byte_word(lcrl_q);
        if (bus_done) state_nx = CFG_CR;
      end
      CFG_CR: begin
        req = 1'b1; req_we = 1'b1;
        req_adr = UART_BASE + OFF_CR; req_dat = byte_word(8'h00);
        if (bus_done) state_nx = READY;
      end
`ifdef UART_WB_CTRL_RX_EN
      READY:    state_nx = i_tx_valid ? POLL_FR : RX_POLL;
`else
      READY:    if (i_tx_valid) state_nx = POLL_FR;
`endif
      POLL_FR: begin
        req = 1'b1; req_adr = UART_BASE + OFF_FR;
        if (bus_done && !i_wb_dat[FR_TXFF]) state_nx = WR_DR;
      end
      WR_DR: begin
        req = 1'b1; req_we = 1'b1;
        req_adr = UART_BASE + OFF_DR; req_dat = byte_word(tx_byte);
        if (bus_done) state_nx = READY;
      end
`ifdef UART_WB_CTRL_RX_EN
      RX_POLL: begin
        req = 1'b1; req_adr = UART_BASE + OFF_FR;
        if (bus_done) state_nx = i_wb_dat[FR_RXFE] ? READY : RX_RD;
      end
      RX_RD: begin
        req = 1'b1; req_adr = UART_BASE + OFF_DR;
        if (bus_done) state_nx = READY;
      end
`endif
      ERROR:    state_nx = ERROR;
      default:  state_nx = IDLE;
    endcase
    // A bus error or ack timeout overrides whatever the current state wanted.
    if (bus_err) state_nx = ERROR;
  end

  assign o_tx_ready  = (state == READY) && i_tx_valid;
  assign o_err       = (state == ERROR);
  assign o_init_done = !(state inside {IDLE, CFG_LCRH, CFG_LCRM, CFG_LCRL, CFG_CR, ERROR});

`ifdef UART_WB_CTRL_RX_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      o_rx_valid <= (state == RX_RD) && bus_done;
      if ((state == RX_RD) && bus_done) o_rx_data <= i_wb_dat[7:0];
    end
  end

  logic unused_rd;
  assign unused_rd = ^i_wb_dat[31:8];
`else
  logic unused_rd;
  assign unused_rd = ^{i_wb_dat[31:6], i_wb_dat[4:0]};
`endif

endmodule

// File: doc/uart_wb_ctrl.md
UART_WB_CTRL -- requirements
Module: uart_wb_ctrl

Interface
REQ-001 SHALL have parameter UART_BASE, default 32'h1600_0000, Wishbone base address of the controlled UART.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, the cycles waited for ack before error.
REQ-003 SHALL use one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-004 Ports, in order:
- i_clk  in  1  clock
- i_rst  in  1  sync active-high reset
- i_start  in  1  pulse: begin configuration
- i_lcrh  in  8  line-control high value
- i_lcrm  in  8  divisor high byte
- i_lcrl  in  8  divisor low byte
- i_tx_valid  in  1  byte offered
- i_tx_data  in  8  byte to transmit
- o_tx_ready  out  1  byte accepted this cycle
- o_wb_adr  out  32  master address
- o_wb_sel  out  4  byte select
- o_wb_we  out  1  write
- o_wb_dat  out  32  write data
- i_wb_dat  in  32  read data
- o_wb_cyc  out  1  cycle
- o_wb_stb  out  1  strobe
- i_wb_ack  in  1  ack
- i_wb_err  in  1  bus error
- o_init_done  out  1  configuration complete
- o_err  out  1  sticky error

Function
REQ-005 FSM states SHALL be IDLE, CFG_LCRH, CFG_LCRM, CFG_LCRL, CFG_CR, READY, POLL_FR, WR_DR, ERROR.
REQ-006 IDLE->CFG_LCRH on i_start; i_start SHALL be ignored outside IDLE.
REQ-007 Each CFG state SHALL issue one write; the order is LCRH (+0x08, i_lcrh), LCRM (+0x0C, i_lcrm), LCRL (+0x10, i_lcrl), then CR (+0x14, 8'h00: interrupts off). Data SHALL be in bits [7:0], o_wb_sel=4'b0001.
REQ-008 Config bytes SHALL be sampled into internal registers on i_start; later input changes SHALL have no effect.
REQ-009 After the CR ack: o_init_done=1, state READY; o_init_done SHALL stay high until reset or ERROR.
REQ-010 READY with i_tx_valid SHALL latch i_tx_data, pulse o_tx_ready for exactly one cycle, and go to POLL_FR; o_tx_ready SHALL be 0 in every other state.
REQ-011 POLL_FR SHALL read FR (+0x18); on ack, i_wb_dat[5] (tx full)=1 SHALL re-poll after one idle cycle, and =0 SHALL go to WR_DR.
REQ-012 WR_DR SHALL write the latched byte to DR (+0x00), then return to READY.
REQ-013 Bus handshake: cyc and stb asserted together and held with stable adr/we/dat/sel until ack or err; both deasserted the cycle after ack; minimum 1 idle cycle between transactions.
REQ-014 Ack and err in the same cycle SHALL be treated as err.
REQ-015 i_wb_err, or ACK_TIMEOUT cycles with stb high and no ack, SHALL go to ERROR: o_err=1, o_init_done=0, bus idle. ERROR SHALL exit only on reset.
REQ-016 The timeout counter SHALL be $clog2(ACK_TIMEOUT+1) bits, cleared at every stb rising edge, and SHALL saturate rather than wrap.

Reset
REQ-017 On i_rst: state IDLE; o_wb_cyc/stb/we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0, o_tx_ready=0, o_init_done=0, o_err=0, counter=0.
REQ-018 Reset mid-transaction SHALL drop cyc/stb the next cycle, and the latched byte SHALL be discarded.

Configuration
REQ-019 Macro UART_WB_CTRL_RX_EN SHALL, when defined, add ports o_rx_valid (out 1) and o_rx_data (out 8), and states RX_POLL and RX_RD.
REQ-020 With the macro defined, READY with i_tx_valid=0 SHALL poll FR; if i_wb_dat[4] (rx empty)=0, RX_RD reads DR and pulses o_rx_valid for one cycle with i_wb_dat[7:0]. TX SHALL have priority in READY.
REQ-021 Without the macro, no RX ports, states or reads SHALL exist, and READY SHALL wait idle.

Structure
REQ-022 Package uart_ctrl_pkg SHALL hold the state enum, the register offsets (DR 0x00, LCRH 0x08, LCRM 0x0C, LCRL 0x10, CR 0x14, FR 0x18) and the FR bit indices (TXFF 5, RXFE 4).
REQ-023 Sub-module uart_wb_master_if SHALL own the single-transaction handshake and timeout, with a req/done/err interface to the FSM.

Verification
REQ-024 Start with lcrh=8'h70, lcrm=8'h00, lcrl=8'h1B, ack 1 cycle later -> writes to 0x16000008/0C/10/14 with data 70/00/1B/00, then o_init_done=1.
REQ-025 In READY send byte 8'h41, FR returns 8'h20 twice then 8'h00 -> three FR reads, then one DR write of 32'h41, then o_tx_ready has pulsed exactly once.
REQ-026 Withhold ack for 16 cycles during the CFG_LCRM write -> o_err=1, cyc=0 the next cycle, o_init_done stays 0.
REQ-027 i_wb_err during WR_DR -> ERROR; i_rst then gives all outputs 0, and i_start then reruns configuration.
REQ-028 With UART_WB_CTRL_RX_EN, tx_valid=0, FR=8'h00, DR=8'h5A -> o_rx_valid pulses once with o_rx_data=8'h5A.
REQ-029 Assert i_rst during an FR read with stb high -> stb=0 the next cycle, state IDLE, the pending byte not written.
